// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 640x480@60 VGA scan-out of a 320x240 RGB565 frame buffer,
// pixel-doubled 2x2, expanded to 8:8:8. Optional colour-bar generator is
// compiled in when TEST_PATTERN_EN is defined.
module vga_fb_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int RD_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [16:0] rd_addr,
   output logic        rd_en,
   input  logic [15:0] rd_data,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start,
   input  logic        test_mode
);

   localparam logic [9:0]  H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [16:0] LINE_STEP = 17'(H_ACTIVE / 2);

   // Control word that travels alongside the RAM read so it lands with rd_data.
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       act;
      logic       fs;
`ifdef TEST_PATTERN_EN
      logic [2:0] bar;
`endif
   } ctl_t;

   localparam ctl_t CTL_IDLE = ctl_t'({1'b1, 1'b1, {($bits(ctl_t) - 2){1'b0}}});

   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [16:0] line_base_q, line_base_d;
   logic [16:0] rd_addr_q, rd_addr_d;
   logic        rd_en_q, rd_en_d;
   logic        active;
   ctl_t        ctl_q [0:RD_LAT];
   ctl_t        ctl_d [0:RD_LAT];
   ctl_t        ctl_out;
   logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
   logic [23:0] rgb_q, rgb_d;

   // RGB565 -> 8:8:8 by replicating the top bits into the new LSBs.
   function automatic logic [23:0] expand565(input logic [15:0] d);
      return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
   endfunction

`ifdef TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   // Bar index of a visible column, found by threshold compares.
   function automatic logic [2:0] bar_of(input logic [9:0] h);
      logic [2:0] idx;
      idx = '0;
      for (int i = 1; i < 8; i++)
         if (h >= 10'(i * BAR_W)) idx = 3'(i);
      return idx;
   endfunction

   // Bar order white..black: each colour bit is the inverse of one index bit.
   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
   endfunction
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
`endif

   // Stage 0: raster counters and per-line-pair address base.
   always_comb begin
      h_cnt_d     = h_cnt_q + 10'd1;
      v_cnt_d     = v_cnt_q;
      line_base_d = line_base_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d     = '0;
            line_base_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
            // Two display lines share one buffer line; advance after the odd one.
            if ((v_cnt_q < V_ACT) && v_cnt_q[0]) line_base_d = line_base_q + LINE_STEP;
         end
      end
   end

   // Active-area decode and the timing word entering the delay line.
   always_comb begin
      active        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      ctl_d[0]      = CTL_IDLE;
      ctl_d[0].hs   = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
      ctl_d[0].vs   = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
      ctl_d[0].act  = active;
      ctl_d[0].fs   = (h_cnt_q == '0) && (v_cnt_q == '0);
`ifdef TEST_PATTERN_EN
      ctl_d[0].bar  = bar_of(h_cnt_q);
`endif
      for (int i = 1; i <= RD_LAT; i++) ctl_d[i] = ctl_q[i - 1];
   end

   // Stage 1: fetch address; each buffer pixel is read for two columns.
   always_comb begin
      rd_en_d   = active;
      rd_addr_d = active ? (line_base_q + {8'd0, h_cnt_q[9:1]}) : '0;
   end

   // Output stage: RAM data meets its delayed timing word here.
   always_comb begin
      ctl_out = ctl_q[RD_LAT];
      hs_d    = ctl_out.hs;
      vs_d    = ctl_out.vs;
      blank_d = ctl_out.act;
      fs_d    = ctl_out.fs;
      rgb_d   = '0;
      if (ctl_out.act) begin
         rgb_d = expand565(rd_data);
`ifdef TEST_PATTERN_EN
         if (test_mode) rgb_d = bar_rgb(ctl_out.bar);
`endif
      end
   end

   // All state: async reset returns pins to idle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         line_base_q <= '0;
         rd_addr_q   <= '0;
         rd_en_q     <= 1'b0;
         for (int i = 0; i <= RD_LAT; i++) ctl_q[i] <= CTL_IDLE;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         blank_q     <= 1'b0;
         fs_q        <= 1'b0;
         rgb_q       <= '0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         line_base_q <= line_base_d;
         rd_addr_q   <= rd_addr_d;
         rd_en_q     <= rd_en_d;
         for (int i = 0; i <= RD_LAT; i++) ctl_q[i] <= ctl_d[i];
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         blank_q     <= blank_d;
         fs_q        <= fs_d;
         rgb_q       <= rgb_d;
      end
   end

   assign rd_addr     = rd_addr_q;
   assign rd_en       = rd_en_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_q;
   assign frame_start = fs_q;
   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: full 640x480 timing (RD_LAT=1) plus two reduced
// geometries (RD_LAT=1 and 3) so whole frames fit in a short run.
module tb_vga_fb_reader;

   typedef struct packed {
      int ha; int hfp; int hsw; int hbp;
      int va; int vfp; int vsw; int vbp;
   } geo_t;

   localparam geo_t GF = '{640, 16, 96, 48, 480, 10, 2, 33};
   localparam geo_t GS = '{16, 2, 4, 2, 8, 1, 2, 2};
   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   localparam logic [23:0] COLS [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h080808};

   logic clk, rst_n, test_mode;
   logic [15:0] mem [0:76799];
   int checks = 0, errors = 0, n;

   logic [16:0] f_addr, s1_addr, s3_addr;
   logic        f_en, s1_en, s3_en;
   logic [15:0] f_dat, s1_dat, s3_dat;
   logic [15:0] s3_pipe [0:1];
   logic        f_hs, f_vs, f_bl, f_fs, s1_hs, s1_vs, s1_bl, s1_fs, s3_hs, s3_vs, s3_bl, s3_fs;
   logic [7:0]  f_r, f_g, f_b, s1_r, s1_g, s1_b, s3_r, s3_g, s3_b;

   vga_fb_reader #(.RD_LAT(1)) u_full (
      .clk(clk), .rst_n(rst_n), .rd_addr(f_addr), .rd_en(f_en), .rd_data(f_dat),
      .vga_hs(f_hs), .vga_vs(f_vs), .vga_blank_n(f_bl), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
      .frame_start(f_fs), .test_mode(test_mode));

   vga_fb_reader #(.H_ACTIVE(GS.ha), .H_FP(GS.hfp), .H_SYNC(GS.hsw), .H_BP(GS.hbp),
                   .V_ACTIVE(GS.va), .V_FP(GS.vfp), .V_SYNC(GS.vsw), .V_BP(GS.vbp),
                   .RD_LAT(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .rd_addr(s1_addr), .rd_en(s1_en), .rd_data(s1_dat),
      .vga_hs(s1_hs), .vga_vs(s1_vs), .vga_blank_n(s1_bl), .vga_r(s1_r), .vga_g(s1_g), .vga_b(s1_b),
      .frame_start(s1_fs), .test_mode(test_mode));

   vga_fb_reader #(.H_ACTIVE(GS.ha), .H_FP(GS.hfp), .H_SYNC(GS.hsw), .H_BP(GS.hbp),
                   .V_ACTIVE(GS.va), .V_FP(GS.vfp), .V_SYNC(GS.vsw), .V_BP(GS.vbp),
                   .RD_LAT(3)) u_s3 (
      .clk(clk), .rst_n(rst_n), .rd_addr(s3_addr), .rd_en(s3_en), .rd_data(s3_dat),
      .vga_hs(s3_hs), .vga_vs(s3_vs), .vga_blank_n(s3_bl), .vga_r(s3_r), .vga_g(s3_g), .vga_b(s3_b),
      .frame_start(s3_fs), .test_mode(test_mode));

   initial clk = 1'b0;
   always #20 clk = ~clk;

   function automatic logic [15:0] fb_word(input int a);
      return (a >= 0 && a < 76800) ? mem[a] : 16'h0000;
   endfunction

   // Synchronous-read RAM models of latency 1 and 3.
   always @(posedge clk) begin
      f_dat      <= fb_word(int'(f_addr));
      s1_dat     <= fb_word(int'(s1_addr));
      s3_pipe[0] <= fb_word(int'(s3_addr));
      s3_pipe[1] <= s3_pipe[0];
      s3_dat     <= s3_pipe[1];
   end

   // Clock edges seen since reset release.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) n <= 0;
      else        n <= n + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {hs,vs,blank_n,frame_start,rgb} after n edges for a pipeline of latency lat+2.
   function automatic logic [27:0] exp_pins(input geo_t g, input int lat, input int cnt);
      int p, ht, vt, h, v, r5, g6, b5;
      logic [15:0] d;
      logic [23:0] rgb;
      logic act, hs, vs, fs;
      ht = g.ha + g.hfp + g.hsw + g.hbp;
      vt = g.va + g.vfp + g.vsw + g.vbp;
      p  = cnt - lat - 2;
      if (p < 0) return {4'b1100, 24'h0};
      h   = p % ht;
      v   = (p / ht) % vt;
      act = (h < g.ha) && (v < g.va);
      hs  = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsw));
      vs  = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsw));
      fs  = (h == 0) && (v == 0);
      rgb = 24'h0;
      if (act) begin
         d   = fb_word((v / 2) * (g.ha / 2) + h / 2);
         r5  = int'(d) >> 11;
         g6  = (int'(d) >> 5) & 63;
         b5  = int'(d) & 31;
         rgb = {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
`ifdef TEST_PATTERN_EN
         if (test_mode) rgb = BARS[h / (g.ha / 8)];
`endif
      end
      return {hs, vs, act, fs, rgb};
   endfunction

   // Expected {rd_en, rd_addr}: the fetch shows up one edge after its counter position.
   function automatic logic [17:0] exp_addr(input geo_t g, input int cnt);
      int q, ht, vt, h, v;
      ht = g.ha + g.hfp + g.hsw + g.hbp;
      vt = g.va + g.vfp + g.vsw + g.vbp;
      q  = cnt - 1;
      if (q < 0) return 18'h0;
      h = q % ht;
      v = (q / ht) % vt;
      if ((h < g.ha) && (v < g.va)) return {1'b1, 17'((v / 2) * (g.ha / 2) + h / 2)};
      return 18'h0;
   endfunction

   task automatic chk_rst(input string tag);
      chk({tag, "_full_pins"}, {f_hs, f_vs, f_bl, f_fs, f_r, f_g, f_b}, {4'b1100, 24'h0});
      chk({tag, "_full_addr"}, {f_en, f_addr}, 18'h0);
      chk({tag, "_s1_pins"}, {s1_hs, s1_vs, s1_bl, s1_fs, s1_r, s1_g, s1_b}, {4'b1100, 24'h0});
      chk({tag, "_s1_addr"}, {s1_en, s1_addr}, 18'h0);
      chk({tag, "_s3_pins"}, {s3_hs, s3_vs, s3_bl, s3_fs, s3_r, s3_g, s3_b}, {4'b1100, 24'h0});
      chk({tag, "_s3_addr"}, {s3_en, s3_addr}, 18'h0);
   endtask

   logic [16:0] s1_max = '0;
   int hs_periods = 0, vs_periods = 0;

   // Cycle-by-cycle comparison against the model, plus sync-pulse measurements.
   initial begin
      logic prev_hs, prev_vs, prev_bl, first_done;
      int hs_fall, vs_fall, pf, ps;
      prev_hs = 1'b1; prev_vs = 1'b1; prev_bl = 1'b0; first_done = 1'b0;
      hs_fall = -1; vs_fall = -1;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("full_pins", {f_hs, f_vs, f_bl, f_fs, f_r, f_g, f_b}, exp_pins(GF, 1, n));
            chk("full_addr", {f_en, f_addr}, exp_addr(GF, n));
            chk("s1_pins", {s1_hs, s1_vs, s1_bl, s1_fs, s1_r, s1_g, s1_b}, exp_pins(GS, 1, n));
            chk("s1_addr", {s1_en, s1_addr}, exp_addr(GS, n));
            chk("s3_pins", {s3_hs, s3_vs, s3_bl, s3_fs, s3_r, s3_g, s3_b}, exp_pins(GS, 3, n));
            chk("s3_addr", {s3_en, s3_addr}, exp_addr(GS, n));
            if (!test_mode) begin
               pf = n - 3;
               ps = n - 5;
               if (pf inside {0, 2, 4, 6}) chk($sformatf("full_col%0d", pf), {f_r, f_g, f_b}, COLS[pf / 2]);
               if (ps inside {0, 2, 4, 6}) chk($sformatf("s3_col%0d", ps), {s3_r, s3_g, s3_b}, COLS[ps / 2]);
            end
            if (f_bl && !prev_bl && !first_done) begin
               chk("first_px", {f_fs, f_r, f_g, f_b}, {1'b1, test_mode ? 24'hFFFFFF : 24'hFF0000});
               first_done = 1'b1;
            end
            if (prev_hs && !f_hs) begin
               if (hs_fall >= 0) begin
                  chk("hs_period", 32'(n - hs_fall), 800);
                  hs_periods++;
               end
               hs_fall = n;
            end
            if (!prev_hs && f_hs && hs_fall >= 0) chk("hs_width", 32'(n - hs_fall), 96);
            if (prev_vs && !s1_vs) begin
               if (vs_fall >= 0) begin
                  chk("vs_period", 32'(n - vs_fall), 312);
                  vs_periods++;
               end
               vs_fall = n;
            end
            if (!prev_vs && s1_vs && vs_fall >= 0) chk("vs_width", 32'(n - vs_fall), 48);
            if (s1_en && s1_addr > s1_max) s1_max = s1_addr;
            prev_hs = f_hs;
            prev_vs = s1_vs;
            prev_bl = f_bl;
         end else begin
            prev_hs = 1'b1; prev_vs = 1'b1; prev_bl = 1'b0; first_done = 1'b0;
            hs_fall = -1; vs_fall = -1;
         end
      end
   end

   // Main sequence: reset, run, mid-frame reset, run, optional pattern run.
   initial begin
      rst_n     = 1'b0;
      test_mode = 1'b0;
      for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
      mem[0] = 16'hF800;
      mem[1] = 16'h07E0;
      mem[2] = 16'h001F;
      mem[3] = 16'h0841;
      repeat (5) @(posedge clk);
      #1 chk_rst("rst");
      @(negedge clk) rst_n = 1'b1;
      repeat (3 * 800 + 300) @(negedge clk);
      #5 rst_n = 1'b0;
      #1 chk_rst("midrst");
      repeat (5) @(posedge clk);
      #1 chk_rst("rsthold");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_fetch", {f_en, f_addr}, {1'b1, 17'd0});
      repeat (1700) @(negedge clk);
`ifdef TEST_PATTERN_EN
      rst_n     = 1'b0;
      test_mode = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (1700) @(negedge clk);
`endif
      chk("s1_last_fetch", 32'(s1_max), 31);
      chk("hs_seen", 32'(hs_periods >= 3), 1);
      chk("vs_seen", 32'(vs_periods >= 2), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
